gcd_control_unit: RTL

- FSM that sequences the W-bit GCD datapath (A/B registers, A/B muxes, subtractor, B==0 and A<B comparators).
- Accepts an operand pair over a val/rdy handshake and loads the datapath registers.
- Iterates swap/subtract steps until B==0, then presents the result over a val/rdy handshake.
- Reports the number of iteration steps used, for performance monitoring.

---
 rtl/gcd_control_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/gcd_control_unit.sv
// rtl/gcd_control_unit.sv - Controller FSM sequencing a swap/subtract GCD datapath.
module gcd_control_unit #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          operands_val,
    output logic          operands_rdy,
    output logic          result_val,
    input  logic          result_rdy,
    input  logic          B_zero,
    input  logic          A_lt_B,
    output logic          A_en,
    output logic          B_en,
    output logic [1:0]    A_mux_sel,
    output logic          B_mux_sel,
    output logic [CW-1:0] iter_count,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] A_SEL_IN  = 2'd0;
    localparam logic [1:0] A_SEL_B   = 2'd1;
    localparam logic [1:0] A_SEL_SUB = 2'd2;
    localparam logic [CW-1:0] ITER_MAX = '1;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] iter_next;
    logic [CW-1:0] iter_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            iter_count <= '0;
        end else begin
            state      <= state_next;
            iter_count <= iter_next;
        end
    end

    // Saturating step counter so long runs never wrap to a misleading small value.
    assign iter_inc = (iter_count == ITER_MAX) ? iter_count : iter_count + CW'(1);

    always_comb begin
        state_next = state;
        iter_next  = iter_count;
        case (state)
            IDLE: begin
                if (operands_val) begin
                    state_next = CALC;
                    iter_next  = '0;
                end
            end
            CALC: begin
                if (A_lt_B || !B_zero) begin
                    iter_next = iter_inc;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (result_rdy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        operands_rdy = 1'b0;
        result_val   = 1'b0;
        A_en         = 1'b0;
        B_en         = 1'b0;
        A_mux_sel    = A_SEL_IN;
        B_mux_sel    = 1'b0;
        busy         = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    operands_rdy = 1'b1;
                    A_en         = 1'b1;
                    B_en         = 1'b1;
                end
                CALC: begin
                    busy = 1'b1;
                    if (A_lt_B) begin
                        A_en      = 1'b1;
                        B_en      = 1'b1;
                        A_mux_sel = A_SEL_B;
                        B_mux_sel = 1'b1;
                    end else if (!B_zero) begin
                        A_en      = 1'b1;
                        A_mux_sel = A_SEL_SUB;
                    end
                end
                DONE: begin
                    busy       = 1'b1;
                    result_val = 1'b1;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

endmodule
